button_event: RTL

//  Converts one debounced push-button level into single-cycle event pulses:
//   - press
//   - long-press
//   - auto-repeat
//   - release

---
 rtl/button_event.sv | 112 +++++++++++
 1 files changed

// File: rtl/button_event.sv
// Turns one debounced button level into press / long-press / auto-repeat / release pulses.
// Optional feature: define BTN_AUTOREPEAT_EN to enable repeat_p pulses while held.
module button_event #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic long_press,
  output logic repeat_p,
  output logic release_p,
  output logic held
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int CNT_MAX_I = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_I);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_C   = CNT_W'(REPEAT_CYCLES);
`endif

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             btn_q;
  logic             press_nx, long_nx, repeat_nx, release_nx;

  // Release always wins over long-press / repeat in the same cycle.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;
    release_nx = 1'b0;
    case (state)
      IDLE: begin
        if (btn && !btn_q) begin
          state_nx = PRESS;
          cnt_nx   = CNT_W'(1);
          press_nx = 1'b1;
        end
      end
      PRESS: begin
        if (!btn) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else if (cnt == LONG_C) begin
          state_nx = HOLD;
          cnt_nx   = CNT_W'(1);
          long_nx  = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!btn) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == REP_C) begin
            repeat_nx = 1'b1;
            cnt_nx    = CNT_W'(1);
          end else if (cnt != CNT_MAX) begin
            cnt_nx = cnt + CNT_W'(1);
          end
`else
          // Without auto-repeat the counter is frozen until release.
          cnt_nx = cnt;
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // btn_q resets high so a button already down at reset must be seen released first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      btn_q      <= 1'b1;
      press      <= 1'b0;
      long_press <= 1'b0;
      repeat_p   <= 1'b0;
      release_p  <= 1'b0;
      held       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      btn_q      <= btn;
      press      <= press_nx;
      long_press <= long_nx;
      repeat_p   <= repeat_nx;
      release_p  <= release_nx;
      held       <= (state_nx != IDLE);
    end
  end

endmodule
